// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply accelerator: controller state encoding,
// default array geometry/latencies and the drain-length helper.
package mm_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFeed,
      StDrain,
      StWrite,
      StDone
   } state_e;

   localparam int unsigned DefArraySize = 4;
   localparam int unsigned DefRdLat     = 1;
   localparam int unsigned DefOutputLat = 3;

   // Cycles from the last feed beat until the last PE row result is stable.
   function automatic int unsigned drain_len(input int unsigned rd_lat,
                                             input int unsigned output_lat,
                                             input int unsigned array_size);
      return rd_lat + output_lat + 2 * array_size - 2;
   endfunction

endpackage

// File: rtl/mm_addr_gen.sv
// Running-sum address generator: an outer (row/column) base plus an inner running
// address, built only from adders. Controls are prioritised init > restart > advance > rewind > step.
module mm_addr_gen
   import mm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter bit          STEP_BY_STRIDE = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ADDR_WIDTH-1:0] base_i,
   input  logic [ADDR_WIDTH-1:0] stride_i,
   input  logic                  init_i,
   input  logic                  step_i,
   input  logic                  advance_i,
   input  logic                  rewind_i,
   input  logic                  restart_i,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [ADDR_WIDTH-1:0] outer_q, outer_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] step_inc, adv_inc;

   // P walks rows by stride and columns by one; A/B walk k by one and tiles by stride.
   assign step_inc = STEP_BY_STRIDE ? stride_q : AddrOne;
   assign adv_inc  = STEP_BY_STRIDE ? AddrOne : stride_q;

   always_comb begin
      base_d   = base_q;
      stride_d = stride_q;
      outer_d  = outer_q;
      addr_d   = addr_q;
      if (init_i) begin
         base_d   = base_i;
         stride_d = stride_i;
         outer_d  = base_i;
         addr_d   = base_i;
      end else if (restart_i) begin
         outer_d = base_q;
         addr_d  = base_q;
      end else if (advance_i) begin
         outer_d = outer_q + adv_inc;
         addr_d  = outer_q + adv_inc;
      end else if (rewind_i) begin
         addr_d = outer_q;
      end else if (step_i) begin
         addr_d = addr_q + step_inc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q   <= '0;
         stride_q <= '0;
         outer_q  <= '0;
         addr_q   <= '0;
      end else begin
         base_q   <= base_d;
         stride_q <= stride_d;
         outer_q  <= outer_d;
         addr_q   <= addr_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/mm_tile_controller.sv
// Tile sequencer for the systolic matrix-multiply array: walks an m x n tile grid (row fastest),
// each tile running feed, drain and write phases back-to-back; all outputs are registered.
module mm_tile_controller
   import mm_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DIM_WIDTH  = 8,
   parameter int unsigned ARRAY_SIZE = DefArraySize,
   parameter int unsigned RD_LAT     = DefRdLat,
   parameter int unsigned OUTPUT_LAT = DefOutputLat
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic                          abort_i,
   input  logic [ADDR_WIDTH-1:0]         base_addra_i,
   input  logic [ADDR_WIDTH-1:0]         base_addrb_i,
   input  logic [ADDR_WIDTH-1:0]         base_addrp_i,
   input  logic [ADDR_WIDTH-1:0]         stride_a_i,
   input  logic [ADDR_WIDTH-1:0]         stride_b_i,
   input  logic [ADDR_WIDTH-1:0]         stride_p_i,
   input  logic [DIM_WIDTH-1:0]          k_i,
   input  logic [DIM_WIDTH-1:0]          m_i,
   input  logic [DIM_WIDTH-1:0]          n_i,
   output logic                          busy_o,
   output logic                          valid_o,
   output logic                          err_o,
   output logic                          ena_o,
   output logic                          enb_o,
   output logic [ADDR_WIDTH-1:0]         addra_o,
   output logic [ADDR_WIDTH-1:0]         addrb_o,
   output logic                          enp_o,
   output logic                          wep_o,
   output logic [ADDR_WIDTH-1:0]         addrp_o,
   output logic [$clog2(ARRAY_SIZE)-1:0] wordp_sel_o,
   output logic                          ensys_o,
   output logic                          pe_we_o,
   output logic                          pe_clr_o
);

   localparam int unsigned Drain = drain_len(RD_LAT, OUTPUT_LAT, ARRAY_SIZE);
   localparam int unsigned SelW  = $clog2(ARRAY_SIZE);
   localparam int unsigned AuxW  = $clog2(Drain + ARRAY_SIZE + 1);
   localparam int unsigned CntW  = (DIM_WIDTH > AuxW) ? DIM_WIDTH : AuxW;

   localparam logic [CntW-1:0]      CntOne    = CntW'(1);
   localparam logic [CntW-1:0]      DrainLast = CntW'(Drain - 1);
   localparam logic [CntW-1:0]      WriteLast = CntW'(ARRAY_SIZE - 1);
   localparam logic [DIM_WIDTH-1:0] DimOne    = DIM_WIDTH'(1);

   state_e state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d, k_last;
   logic [DIM_WIDTH-1:0] r_q, r_d, c_q, c_d;
   logic [DIM_WIDTH-1:0] k_q, k_d, m_q, m_d, n_q, n_d;
   logic                 last_r, last_c, flush;

   logic gen_init, ab_step, a_adv, a_restart, b_adv, b_rewind, p_step, p_adv;
   logic err_d, busy_d, valid_d, ena_d, first_d, wep_d;
   logic [SelW-1:0] wsel_d;
   logic busy_q, valid_q, err_q, ena_q, first_q, wep_q;
   logic [SelW-1:0] wsel_q;
   logic [RD_LAT-1:0] we_pipe_q, we_pipe_d, clr_pipe_q, clr_pipe_d;

   assign k_last = CntW'(k_q) - CntOne;
   assign last_r = (r_q == m_q - DimOne);
   assign last_c = (c_q == n_q - DimOne);
   assign flush  = (state_q != StIdle) && abort_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      r_d       = r_q;
      c_d       = c_q;
      k_d       = k_q;
      m_d       = m_q;
      n_d       = n_q;
      err_d     = 1'b0;
      gen_init  = 1'b0;
      ab_step   = 1'b0;
      a_adv     = 1'b0;
      a_restart = 1'b0;
      b_adv     = 1'b0;
      b_rewind  = 1'b0;
      p_step    = 1'b0;
      p_adv     = 1'b0;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i && !abort_i) begin
                  k_d = k_i;
                  m_d = m_i;
                  n_d = n_i;
                  if (k_i == '0 || m_i == '0 || n_i == '0) begin
                     err_d = 1'b1;
                  end else begin
                     state_d  = StFeed;
                     cnt_d    = '0;
                     r_d      = '0;
                     c_d      = '0;
                     gen_init = 1'b1;
                  end
               end
            end
            StFeed: begin
               ab_step = 1'b1;
               if (cnt_q == k_last) begin
                  state_d = StDrain;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            StDrain: begin
               if (cnt_q == DrainLast) begin
                  state_d = StWrite;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            StWrite: begin
               p_step = 1'b1;
               if (cnt_q == WriteLast) begin
                  cnt_d = '0;
                  if (last_r && last_c) begin
                     state_d = StDone;
                  end else if (last_r) begin
                     // Next column: A back to row 0, B and P move one column over.
                     state_d   = StFeed;
                     r_d       = '0;
                     c_d       = c_q + DimOne;
                     a_restart = 1'b1;
                     b_adv     = 1'b1;
                     p_adv     = 1'b1;
                  end else begin
                     // P already stepped onto the next tile row block.
                     state_d  = StFeed;
                     r_d      = r_q + DimOne;
                     a_adv    = 1'b1;
                     b_rewind = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy_d  = (state_d != StIdle);
      ena_d   = (state_d == StFeed);
      first_d = (state_d == StFeed) && (cnt_d == '0);
      wep_d   = (state_d == StWrite);
      wsel_d  = wep_d ? cnt_d[SelW-1:0] : '0;
      valid_d = err_d || (state_d == StDone);
      we_pipe_d  = '0;
      clr_pipe_d = '0;
      if (!flush) begin
         we_pipe_d[0]  = ena_q;
         clr_pipe_d[0] = first_q;
         for (int i = 1; i < RD_LAT; i++) begin
            we_pipe_d[i]  = we_pipe_q[i-1];
            clr_pipe_d[i] = clr_pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         r_q        <= '0;
         c_q        <= '0;
         k_q        <= '0;
         m_q        <= '0;
         n_q        <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         ena_q      <= 1'b0;
         first_q    <= 1'b0;
         wep_q      <= 1'b0;
         wsel_q     <= '0;
         we_pipe_q  <= '0;
         clr_pipe_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         r_q        <= r_d;
         c_q        <= c_d;
         k_q        <= k_d;
         m_q        <= m_d;
         n_q        <= n_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         ena_q      <= ena_d;
         first_q    <= first_d;
         wep_q      <= wep_d;
         wsel_q     <= wsel_d;
         we_pipe_q  <= we_pipe_d;
         clr_pipe_q <= clr_pipe_d;
      end
   end

   mm_addr_gen #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .STEP_BY_STRIDE(1'b0)
   ) u_gen_a (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .base_i   (base_addra_i),
      .stride_i (stride_a_i),
      .init_i   (gen_init),
      .step_i   (ab_step),
      .advance_i(a_adv),
      .rewind_i (1'b0),
      .restart_i(a_restart),
      .addr_o   (addra_o)
   );

   mm_addr_gen #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .STEP_BY_STRIDE(1'b0)
   ) u_gen_b (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .base_i   (base_addrb_i),
      .stride_i (stride_b_i),
      .init_i   (gen_init),
      .step_i   (ab_step),
      .advance_i(b_adv),
      .rewind_i (b_rewind),
      .restart_i(1'b0),
      .addr_o   (addrb_o)
   );

   mm_addr_gen #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .STEP_BY_STRIDE(1'b1)
   ) u_gen_p (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .base_i   (base_addrp_i),
      .stride_i (stride_p_i),
      .init_i   (gen_init),
      .step_i   (p_step),
      .advance_i(p_adv),
      .rewind_i (1'b0),
      .restart_i(1'b0),
      .addr_o   (addrp_o)
   );

   assign busy_o      = busy_q;
   assign ensys_o     = busy_q;
   assign valid_o     = valid_q;
   assign err_o       = err_q;
   assign ena_o       = ena_q;
   assign enb_o       = ena_q;
   assign enp_o       = wep_q;
   assign wep_o       = wep_q;
   assign wordp_sel_o = wsel_q;
   assign pe_we_o     = we_pipe_q[RD_LAT-1];
   assign pe_clr_o    = clr_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_mm_tile_controller.sv
// Directed bench for mm_tile_controller with default parameters (tile = k + 10 + 4 cycles).
module tb_mm_tile_controller;

   logic        clk, rst_n, start, abort;
   logic [15:0] ba, bb, bp, sa, sb, sp;
   logic [7:0]  k, m, n;
   logic        busy, valid, err, ena, enb, enp, wep, ensys, pe_we, pe_clr;
   logic [15:0] addra, addrb, addrp;
   logic [1:0]  wsel;
   logic [9:0]  ctl;

   int tests = 0;
   int fails = 0;

   mm_tile_controller dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .base_addra_i(ba),
      .base_addrb_i(bb),
      .base_addrp_i(bp),
      .stride_a_i  (sa),
      .stride_b_i  (sb),
      .stride_p_i  (sp),
      .k_i         (k),
      .m_i         (m),
      .n_i         (n),
      .busy_o      (busy),
      .valid_o     (valid),
      .err_o       (err),
      .ena_o       (ena),
      .enb_o       (enb),
      .addra_o     (addra),
      .addrb_o     (addrb),
      .enp_o       (enp),
      .wep_o       (wep),
      .addrp_o     (addrp),
      .wordp_sel_o (wsel),
      .ensys_o     (ensys),
      .pe_we_o     (pe_we),
      .pe_clr_o    (pe_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ctl = {busy, ensys, ena, enb, pe_we, pe_clr, enp, wep, valid, err};

   // Expected control bits for cycle cyc of a job started in cycle 0.
   function automatic logic [9:0] exp_ctl(input int cyc, input int kk, input int tiles);
      int   tl;
      int   ph;
      logic b, f, we, clr, w, v;
      tl = kk + 14;
      b = 0; f = 0; we = 0; clr = 0; w = 0; v = 0;
      if (cyc >= 1 && cyc <= tiles * tl) begin
         ph  = (cyc - 1) % tl;
         b   = 1;
         f   = (ph < kk);
         we  = (ph >= 1) && (ph <= kk);
         clr = (ph == 1);
         w   = (ph >= kk + 10);
      end else if (cyc == tiles * tl + 1) begin
         b = 1;
         v = 1;
      end
      return {b, b, f, f, we, clr, w, w, v, 1'b0};
   endfunction

   task automatic set_cfg(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                          input logic [15:0] s_a, input logic [15:0] s_b, input logic [15:0] s_p,
                          input logic [7:0] kv, input logic [7:0] mv, input logic [7:0] nv);
      ba = a; bb = b; bp = p; sa = s_a; sb = s_b; sp = s_p; k = kv; m = mv; n = nv;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({ctl, addra, addrb, addrp, wsel} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got ctl=%b a=%h b=%h p=%h, want all 0", ctl, addra, addrb,
                  addrp);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (ctl !== 10'b0) begin
         fails++;
         $display("FAIL reset_release_idle: got ctl=%b want 0", ctl);
      end
   endtask

   task automatic test_single_tile;
      set_cfg(16'h000, 16'h100, 16'h200, 16'h10, 16'h10, 16'h10, 8'd2, 8'd1, 8'd1);
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         tests++;
         if (ctl !== exp_ctl(cyc, 2, 1)) begin
            fails++;
            $display("FAIL single_ctl cyc %0d: got %b want %b", cyc, ctl, exp_ctl(cyc, 2, 1));
         end
         if (cyc <= 2) begin
            tests++;
            if (addra !== 16'(cyc - 1) || addrb !== 16'(16'h100 + cyc - 1)) begin
               fails++;
               $display("FAIL single_ab cyc %0d: got %h/%h want %h/%h", cyc, addra, addrb,
                        16'(cyc - 1), 16'(16'h100 + cyc - 1));
            end
         end
         if (cyc >= 13 && cyc <= 16) begin
            tests++;
            if (addrp !== 16'(16'h200 + (cyc - 13) * 16) || wsel !== 2'(cyc - 13)) begin
               fails++;
               $display("FAIL single_p cyc %0d: got %h sel %0d want %h sel %0d", cyc, addrp, wsel,
                        16'(16'h200 + (cyc - 13) * 16), cyc - 13);
            end
         end
      end
   endtask

   task automatic test_multi_tile;
      int t, ph, r, c;
      set_cfg(16'h000, 16'h100, 16'h200, 16'h20, 16'h40, 16'h10, 8'd3, 8'd2, 8'd2);
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         tests++;
         if (ctl !== exp_ctl(cyc, 3, 4)) begin
            fails++;
            $display("FAIL multi_ctl cyc %0d: got %b want %b", cyc, ctl, exp_ctl(cyc, 3, 4));
         end
         if (cyc <= 68) begin
            t  = (cyc - 1) / 17;
            ph = (cyc - 1) % 17;
            r  = t % 2;
            c  = t / 2;
            if (ph < 3) begin
               tests++;
               if (addra !== 16'(r * 32 + ph) || addrb !== 16'(256 + c * 64 + ph)) begin
                  fails++;
                  $display("FAIL multi_ab cyc %0d: got %h/%h want %h/%h", cyc, addra, addrb,
                           16'(r * 32 + ph), 16'(256 + c * 64 + ph));
               end
            end
            if (ph >= 13) begin
               tests++;
               if (addrp !== 16'(512 + (r * 4 + ph - 13) * 16 + c)) begin
                  fails++;
                  $display("FAIL multi_p cyc %0d: got %h want %h", cyc, addrp,
                           16'(512 + (r * 4 + ph - 13) * 16 + c));
               end
            end
         end
      end
   endtask

   task automatic test_zero_dim;
      set_cfg(16'h000, 16'h100, 16'h200, 16'h10, 16'h10, 16'h10, 8'd2, 8'd0, 8'd1);
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         tests++;
         if (ctl !== ((cyc == 1) ? 10'b0000000011 : 10'b0)) begin
            fails++;
            $display("FAIL zero_dim cyc %0d: got %b want %b", cyc, ctl,
                     (cyc == 1) ? 10'b0000000011 : 10'b0);
         end
      end
   endtask

   task automatic test_abort;
      set_cfg(16'h000, 16'h100, 16'h200, 16'h10, 16'h10, 16'h10, 8'd2, 8'd1, 8'd1);
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         tests++;
         if (ctl !== ((cyc <= 14) ? exp_ctl(cyc, 2, 1) : 10'b0)) begin
            fails++;
            $display("FAIL abort_write cyc %0d: got %b want %b", cyc, ctl,
                     (cyc <= 14) ? exp_ctl(cyc, 2, 1) : 10'b0);
         end
         if (cyc == 14) abort = 1'b1;
      end
      // Abort on the first feed beat must also cancel the pending pe_we.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (ctl !== 10'b0) begin
         fails++;
         $display("FAIL abort_feed_flush: got %b want 0", ctl);
      end
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         tests++;
         if (ctl !== exp_ctl(cyc, 2, 1)) begin
            fails++;
            $display("FAIL abort_restart cyc %0d: got %b want %b", cyc, ctl, exp_ctl(cyc, 2, 1));
         end
      end
   endtask

   task automatic test_wrap;
      set_cfg(16'hFFFE, 16'h100, 16'h200, 16'h10, 16'h10, 16'h10, 8'd4, 8'd1, 8'd1);
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         tests++;
         if (ctl !== exp_ctl(cyc, 4, 1)) begin
            fails++;
            $display("FAIL wrap_ctl cyc %0d: got %b want %b", cyc, ctl, exp_ctl(cyc, 4, 1));
         end
         if (cyc <= 4) begin
            tests++;
            if (addra !== 16'(32'hFFFE + cyc - 1)) begin
               fails++;
               $display("FAIL wrap_addra cyc %0d: got %h want %h", cyc, addra,
                        16'(32'hFFFE + cyc - 1));
            end
         end
      end
   endtask

   task automatic test_start_busy;
      set_cfg(16'h000, 16'h100, 16'h200, 16'h10, 16'h10, 16'h10, 8'd2, 8'd1, 8'd1);
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         tests++;
         if (ctl !== exp_ctl(cyc, 2, 1)) begin
            fails++;
            $display("FAIL busy_ctl cyc %0d: got %b want %b", cyc, ctl, exp_ctl(cyc, 2, 1));
         end
         if (cyc >= 13 && cyc <= 16) begin
            tests++;
            if (addrp !== 16'(16'h200 + (cyc - 13) * 16)) begin
               fails++;
               $display("FAIL busy_p cyc %0d: got %h want %h", cyc, addrp,
                        16'(16'h200 + (cyc - 13) * 16));
            end
         end
         // Repeated starts with altered config while busy must change nothing.
         if (cyc == 5 || cyc == 13 || cyc == 17) begin
            start = 1'b1;
            set_cfg(16'h050, 16'h150, 16'h300, 16'h20, 16'h20, 16'h20, 8'd9, 8'd0, 8'd1);
         end
      end
   endtask

   task automatic test_start_abort_idle;
      set_cfg(16'h000, 16'h100, 16'h200, 16'h10, 16'h10, 16'h10, 8'd2, 8'd1, 8'd1);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         tests++;
         if (ctl !== 10'b0) begin
            fails++;
            $display("FAIL start_abort_idle cyc %0d: got %b want 0", cyc, ctl);
         end
      end
   endtask

   task automatic test_reset_mid;
      set_cfg(16'h040, 16'h140, 16'h240, 16'h10, 16'h10, 16'h10, 8'd4, 8'd1, 8'd1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({ctl, addra, addrb, addrp, wsel} !== '0) begin
         fails++;
         $display("FAIL reset_mid: got ctl=%b a=%h b=%h p=%h, want all 0", ctl, addra, addrb,
                  addrp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         tests++;
         if (ctl !== 10'b0) begin
            fails++;
            $display("FAIL reset_mid_idle cyc %0d: got %b want 0", cyc, ctl);
         end
      end
   endtask

   initial begin
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b0;
      set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'd0, 8'd0, 8'd0);
      test_reset();
      test_single_tile();
      test_multi_tile();
      test_zero_dim();
      test_abort();
      test_wrap();
      test_start_busy();
      test_start_abort_idle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
